// File: rtl/buzzer_pattern.sv
// Buzzer pattern generator: silent, continuous, one-shot or burst-loop beeps with optional tone.
// Outputs registered, 1 edge after a sel change; no backpressure, sel is sampled every edge.
module buzzer_pattern #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int ON_MS   = 100,
  parameter int OFF_MS  = 100,
  parameter int GAP_MS  = 250,
  parameter int BURST_N = 3,
  parameter int LONG_MS = 500,
  parameter int TONE_HZ = 0
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [1:0]                                  sel,
  output logic                                        buzz,
  output logic                                        active,
  output logic [((BURST_N > 1) ? $clog2(BURST_N) : 1)-1:0] beep_idx
);

  localparam int CPM    = CLK_HZ / 1000;
  localparam int ON_C   = CPM * ON_MS;
  localparam int OFF_C  = CPM * OFF_MS;
  localparam int GAP_C  = CPM * GAP_MS;
  localparam int LONG_C = CPM * LONG_MS;
  localparam int MAX_AB = (ON_C > OFF_C) ? ON_C : OFF_C;
  localparam int MAX_CD = (GAP_C > LONG_C) ? GAP_C : LONG_C;
  localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TMW    = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int BW     = (BURST_N > 1) ? $clog2(BURST_N) : 1;
  localparam bit TONE_EN = (TONE_HZ > 0);
  localparam int HALF   = TONE_EN ? CLK_HZ / (2 * TONE_HZ) : 1;
  localparam int TW     = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [TMW-1:0] ON_END   = TMW'(ON_C - 1);
  localparam logic [TMW-1:0] OFF_END  = TMW'(OFF_C - 1);
  localparam logic [TMW-1:0] GAP_END  = TMW'(GAP_C - 1);
  localparam logic [TMW-1:0] LONG_END = TMW'(LONG_C - 1);
  localparam logic [BW-1:0]  BURST_LAST = BW'(BURST_N - 1);
  localparam logic [TW-1:0]  HALF_END   = TW'(HALF - 1);

  if (TONE_EN && HALF < 1) begin : g_tone_chk
    $error("buzzer_pattern: tone half period is below one clock cycle");
  end

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

  state_t         state, state_n;
  logic [1:0]     sel_q;
  logic [TMW-1:0] timer, timer_n;
  logic [BW-1:0]  idx_n;
  logic [TW-1:0]  tcnt, tcnt_n;
  logic           tph, tph_n;
  logic           changed, on_entry, buzz_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel_q    <= 2'b00;
      timer    <= '0;
      beep_idx <= '0;
      tcnt     <= '0;
      tph      <= 1'b0;
      buzz     <= 1'b0;
      active   <= 1'b0;
    end else begin
      state    <= state_n;
      sel_q    <= sel;
      timer    <= timer_n;
      beep_idx <= idx_n;
      tcnt     <= tcnt_n;
      tph      <= tph_n;
      buzz     <= buzz_n;
      active   <= (state_n == ON);
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    idx_n   = beep_idx;
    tcnt_n  = tcnt;
    tph_n   = tph;
    changed = (sel != sel_q);

    // A mode change pre-empts any phase transition due on the same edge.
    if (changed) begin
      timer_n = '0;
      idx_n   = '0;
      state_n = (sel == 2'b00) ? IDLE : ON;
    end else begin
      case (state)
        IDLE: timer_n = '0;
        ON: begin
          case (sel_q)
            2'b01: timer_n = '0;
            2'b10: begin
              if (timer == LONG_END) begin
                state_n = IDLE;
                timer_n = '0;
              end else timer_n = timer + 1'b1;
            end
            2'b11: begin
              if (timer == ON_END) begin
                state_n = (beep_idx == BURST_LAST) ? GAP : OFF;
                timer_n = '0;
              end else timer_n = timer + 1'b1;
            end
            default: begin
              state_n = IDLE;
              timer_n = '0;
            end
          endcase
        end
        OFF: begin
          if (timer == OFF_END) begin
            state_n = ON;
            timer_n = '0;
            idx_n   = beep_idx + 1'b1;
          end else timer_n = timer + 1'b1;
        end
        GAP: begin
          if (timer == GAP_END) begin
            state_n = ON;
            timer_n = '0;
            idx_n   = '0;
          end else timer_n = timer + 1'b1;
        end
        default: begin
          state_n = IDLE;
          timer_n = '0;
        end
      endcase
    end

    // Tone restarts high at every ON entry, including a mode change into ON.
    on_entry = (state_n == ON) && ((state != ON) || changed);
    if (on_entry) begin
      tcnt_n = '0;
      tph_n  = 1'b1;
    end else if (state_n == ON) begin
      if (tcnt == HALF_END) begin
        tcnt_n = '0;
        tph_n  = ~tph;
      end else tcnt_n = tcnt + 1'b1;
    end else begin
      tcnt_n = '0;
      tph_n  = 1'b0;
    end

    buzz_n = (state_n == ON) && (TONE_EN ? tph_n : 1'b1);
  end

endmodule

// File: tb/tb_buzzer_pattern.sv
// Directed bench for buzzer_pattern at 1 cycle/ms: DC-level instance plus a 250 Hz tone instance.
module tb_buzzer_pattern;

  logic       clk;
  logic       rst;
  logic [1:0] sel, sel_t;
  logic       buzz, active, buzz_t, active_t;
  logic [1:0] beep_idx, beep_idx_t;

  int tests = 0;
  int fails = 0;

  buzzer_pattern #(
    .CLK_HZ(1000), .ON_MS(4), .OFF_MS(2), .GAP_MS(6),
    .BURST_N(3), .LONG_MS(10), .TONE_HZ(0)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel),
    .buzz(buzz), .active(active), .beep_idx(beep_idx)
  );

  buzzer_pattern #(
    .CLK_HZ(1000), .ON_MS(4), .OFF_MS(2), .GAP_MS(6),
    .BURST_N(3), .LONG_MS(10), .TONE_HZ(250)
  ) dut_t (
    .clk(clk), .rst(rst), .sel(sel_t),
    .buzz(buzz_t), .active(active_t), .beep_idx(beep_idx_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Burst pattern, k = edges since the edge that first sampled sel=11.
  function automatic logic burst_buzz(input int k);
    int p = k % 22;
    return (p < 4) || (p >= 6 && p < 10) || (p >= 12 && p < 16);
  endfunction

  function automatic logic [1:0] burst_idx(input int k);
    int p = k % 22;
    return (p < 6) ? 2'd0 : (p < 12) ? 2'd1 : 2'd2;
  endfunction

  task automatic chk_burst(input string tag, input int k);
    chk({tag, "_buzz"},   buzz,     burst_buzz(k));
    chk({tag, "_active"}, active,   burst_buzz(k));
    chk({tag, "_idx"},    beep_idx, burst_idx(k));
  endtask

  initial begin
    rst = 1'b1; sel = 2'b00; sel_t = 2'b00;

    // 1. reset state
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_buzz", buzz, 1'b0);
      chk("rst_active", active, 1'b0);
      chk("rst_idx", beep_idx, 2'd0);
      chk("rst_tone_buzz", buzz_t, 1'b0);
    end
    rst = 1'b0;
    tick();
    chk("idle_buzz", buzz, 1'b0);

    // 2. burst loop
    sel = 2'b11;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk_burst("burst", k);
    end
    sel = 2'b00;
    tick();
    chk("burst_stop_buzz", buzz, 1'b0);
    chk("burst_stop_idx", beep_idx, 2'd0);

    // 3. one-shot, no retrigger, then re-fire
    sel = 2'b10;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("oneshot_buzz", buzz, (k < 10));
      chk("oneshot_active", active, (k < 10));
    end
    sel = 2'b00;
    tick();
    chk("oneshot_off", buzz, 1'b0);
    sel = 2'b10;
    for (int k = 0; k < 14; k++) begin
      tick();
      chk("refire_buzz", buzz, (k < 10));
    end
    sel = 2'b00;
    tick();

    // 4. burst -> continuous mid-OFF
    sel = 2'b11;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_burst("pre_cont", k);
    end
    sel = 2'b01;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("cont_buzz", buzz, 1'b1);
      chk("cont_active", active, 1'b1);
      chk("cont_idx", beep_idx, 2'd0);
    end
    sel = 2'b00;
    tick();
    chk("cont_stop", buzz, 1'b0);

    // 5. reset pulse during the second beep
    sel = 2'b11;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_burst("pre_rst", k);
    end
    rst = 1'b1;
    tick();
    chk("midrst_buzz", buzz, 1'b0);
    chk("midrst_active", active, 1'b0);
    chk("midrst_idx", beep_idx, 2'd0);
    rst = 1'b0;
    for (int k = 0; k < 26; k++) begin
      tick();
      chk_burst("post_rst", k);
    end
    sel = 2'b00;
    tick();

    // 6. tone instance, H = 2 cycles
    sel_t = 2'b01;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("tone_buzz", buzz_t, ((k % 4) < 2));
      chk("tone_active", active_t, 1'b1);
    end
    sel_t = 2'b00;
    tick();
    chk("tone_off_buzz", buzz_t, 1'b0);
    chk("tone_off_active", active_t, 1'b0);
    tick();
    chk("tone_off_buzz2", buzz_t, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
